// File: rtl/config_packet_sequencer.sv
// UART auto-configuration master: sends data-width, parity, stop-bits and end packets,
// waits for an acknowledge after each, retries on timeout. Optional macro: CFG_SANITIZE_EN.
module config_packet_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter logic [7:0]  ACKN_PKT       = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [1:0] cfg_data_width_i,
  input  logic [1:0] cfg_parity_mode_i,
  input  logic [1:0] cfg_stop_bits_i,
  input  logic       tx_fifo_full_i,
  output logic       tx_fifo_write_o,
  output logic [7:0] tx_data_o,
  input  logic       rx_fifo_empty_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_fifo_read_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic       sanitized_o
);

  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    ATT_MAX    = 2'(MAX_ATTEMPTS);

  // state    | meaning
  // S_IDLE   | waiting for start_i
  // S_SEND   | writing packet idx to the TX FIFO
  // S_WAIT   | waiting for the acknowledge byte, timer running
  // S_DONE   | one-cycle success pulse
  // S_FAIL   | one-cycle failure pulse
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  logic [2:0]    r_state;
  logic [1:0]    r_idx;
  logic [1:0]    r_attempts;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_width;
  logic [1:0]    r_parity;
  logic [1:0]    r_stop;

  logic          w_write;
  logic          w_pop;
  logic [7:0]    w_pkt;
  logic [1:0]    w_stop_latch;

`ifdef CFG_SANITIZE_EN
  logic r_sanitized;

  // Reserved stop-bits code is replaced by the 1-stop-bit code before it is latched.
  assign w_stop_latch = (cfg_stop_bits_i == 2'b11) ? 2'b00 : cfg_stop_bits_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sanitized <= 1'b0;
    end else if (r_state == S_IDLE && start_i) begin
      r_sanitized <= (cfg_stop_bits_i == 2'b11);
    end
  end

  assign sanitized_o = r_sanitized;
`else
  assign w_stop_latch = cfg_stop_bits_i;
  assign sanitized_o  = 1'b0;
`endif

  // Strobes are masked while reset is held so no FIFO side effect leaks out.
  assign w_write = (r_state == S_SEND) && !tx_fifo_full_i && rst_n_i;
  assign w_pop   = (r_state == S_WAIT) && !rx_fifo_empty_i && rst_n_i;

  always_comb begin
    w_pkt = 8'h00;
    case (r_idx)
      2'd0:    w_pkt = {2'b01, 4'b0000, r_width};
      2'd1:    w_pkt = {2'b10, 4'b0000, r_parity};
      2'd2:    w_pkt = {2'b11, 4'b0000, r_stop};
      default: w_pkt = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_attempts <= 2'd0;
      r_timer    <= '0;
      r_width    <= 2'd0;
      r_parity   <= 2'd0;
      r_stop     <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_width    <= cfg_data_width_i;
            r_parity   <= cfg_parity_mode_i;
            r_stop     <= w_stop_latch;
            r_idx      <= 2'd0;
            r_attempts <= 2'd0;
            r_timer    <= '0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_write) begin
            r_attempts <= r_attempts + 2'd1;
            r_timer    <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An available byte takes priority over a coincident timeout.
          if (w_pop) begin
            if (rx_data_i != ACKN_PKT) begin
              r_state <= S_FAIL;
            end else if (r_idx == 2'd3) begin
              r_state <= S_DONE;
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_attempts <= 2'd0;
              r_state    <= S_SEND;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_state <= (r_attempts == ATT_MAX) ? S_FAIL : S_SEND;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAIL:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_fifo_write_o = w_write;
  assign tx_data_o       = (r_state == S_SEND) ? w_pkt : 8'h00;
  assign rx_fifo_read_o  = w_pop;
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = (r_state == S_DONE);
  assign error_o         = (r_state == S_FAIL);

endmodule

// File: tb/tb_config_packet_sequencer.sv
// Self-checking bench for config_packet_sequencer: a cycle-level FIFO/responder
// environment plus an arithmetic timeline model of writes, pops and the final pulse.
module tb_config_packet_sequencer;
  localparam int TO   = 100;
  localparam int MAXA = 3;

  logic       clk = 1'b0;
  logic       rst_n_i, start_i;
  logic [1:0] cfg_data_width_i, cfg_parity_mode_i, cfg_stop_bits_i;
  logic       tx_fifo_full_i, rx_fifo_empty_i;
  logic [7:0] rx_data_i;
  logic       tx_fifo_write_o, rx_fifo_read_o, busy_o, done_o, error_o, sanitized_o;
  logic [7:0] tx_data_o;

  always #5 clk = ~clk;

  config_packet_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_ATTEMPTS(MAXA), .ACKN_PKT(8'hFF)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i),
    .cfg_data_width_i(cfg_data_width_i), .cfg_parity_mode_i(cfg_parity_mode_i),
    .cfg_stop_bits_i(cfg_stop_bits_i),
    .tx_fifo_full_i(tx_fifo_full_i), .tx_fifo_write_o(tx_fifo_write_o), .tx_data_o(tx_data_o),
    .rx_fifo_empty_i(rx_fifo_empty_i), .rx_data_i(rx_data_i), .rx_fifo_read_o(rx_fifo_read_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .sanitized_o(sanitized_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int full_until = 0;
  bit rst_val = 1'b0;
  bit start_req = 1'b0;
  logic [1:0] p_w, p_p, p_s;
  int dly [16];
  logic [7:0] rep [16];
  int nwr;
  logic [7:0] rxq [$];
  int rxr [$];
  string obs_w, obs_wd, obs_p, obs_end, exp_w, exp_p, exp_end;
  bit busy_after;
  bit exp_san;

  // One clock: drive inputs on the falling edge, sample the outputs 2 ns later.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    rst_n_i = rst_val;
    start_i = start_req | (busy_o === 1'b1 && $urandom_range(0, 3) == 0);
    cfg_data_width_i  = start_req ? p_w : 2'($urandom);
    cfg_parity_mode_i = start_req ? p_p : 2'($urandom);
    cfg_stop_bits_i   = start_req ? p_s : 2'($urandom);
    start_req = 1'b0;
    tx_fifo_full_i = (cyc < full_until);
    if (rxq.size() > 0 && rxr[0] <= cyc) begin
      rx_fifo_empty_i = 1'b0;
      rx_data_i = rxq[0];
    end else begin
      rx_fifo_empty_i = 1'b1;
      rx_data_i = 8'h00;
    end
    #2;
    if (tx_fifo_write_o === 1'b1) begin
      obs_w  = {obs_w, $sformatf("%0d:%h ", cyc, tx_data_o)};
      obs_wd = {obs_wd, $sformatf("%h ", tx_data_o)};
      if (nwr < 16 && dly[nwr] >= 1 && dly[nwr] <= TO) begin
        rxq.push_back(rep[nwr]);
        rxr.push_back(cyc + dly[nwr]);
      end
      nwr++;
    end
    if (rx_fifo_read_o === 1'b1) begin
      obs_p = {obs_p, $sformatf("%0d ", cyc)};
      if (!rx_fifo_empty_i) begin
        void'(rxq.pop_front());
        void'(rxr.pop_front());
      end
    end
    if (done_o === 1'b1)  obs_end = {obs_end, $sformatf("D%0d ", cyc)};
    if (error_o === 1'b1) obs_end = {obs_end, $sformatf("E%0d ", cyc)};
  endtask

  task automatic set_policy(input int d);
    for (int i = 0; i < 16; i++) begin
      dly[i] = d;
      rep[i] = 8'hFF;
    end
  endtask

  // Timeline model: write at first non-full cycle after entering SEND; ack within TO wait
  // cycles pops and moves on next cycle; otherwise resend/fail TO+1 cycles after the write.
  task automatic run_scenario(input logic [1:0] w, input logic [1:0] p, input logic [1:0] s,
                              input int full_len);
    logic [7:0] pk [4];
    logic [1:0] se;
    int t, wt, k, d, start_cyc;
    bit fin;
    obs_w = ""; obs_wd = ""; obs_p = ""; obs_end = "";
    exp_w = ""; exp_p = ""; exp_end = "";
    nwr = 0;
    rxq.delete();
    rxr.delete();
    se = s;
    exp_san = 1'b0;
`ifdef CFG_SANITIZE_EN
    if (s == 2'b11) begin
      se = 2'b00;
      exp_san = 1'b1;
    end
`endif
    pk[0] = {2'b01, 4'b0000, w};
    pk[1] = {2'b10, 4'b0000, p};
    pk[2] = {2'b11, 4'b0000, se};
    pk[3] = 8'h00;
    start_cyc  = cyc + 1;
    full_until = start_cyc + 1 + full_len;
    t = start_cyc + 1;
    k = 0;
    fin = 1'b0;
    for (int idx = 0; idx < 4 && !fin; idx++) begin
      for (int a = 1; a <= MAXA; a++) begin
        wt = (t > full_until) ? t : full_until;
        exp_w = {exp_w, $sformatf("%0d:%h ", wt, pk[idx])};
        d = dly[k];
        if (d >= 1 && d <= TO) begin
          exp_p = {exp_p, $sformatf("%0d ", wt + d)};
          if (rep[k] != 8'hFF) begin
            exp_end = $sformatf("E%0d ", wt + d + 1);
            fin = 1'b1;
          end
          t = wt + d + 1;
          k++;
          break;
        end else if (a == MAXA) begin
          exp_end = $sformatf("E%0d ", wt + TO + 1);
          fin = 1'b1;
        end else begin
          t = wt + TO + 1;
        end
        k++;
      end
    end
    if (!fin) exp_end = $sformatf("D%0d ", t);

    p_w = w; p_p = p; p_s = s;
    start_req = 1'b1;
    cycle();
    while (obs_end == "" && cyc < start_cyc + 2000) cycle();
    cycle();
    busy_after = busy_o;
  endtask

  task automatic test_reset();
    rst_val = 1'b0;
    repeat (3) cycle();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done_o); end
    total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset error: got %b want 0", error_o); end
    total++; if (tx_fifo_write_o !== 1'b0) begin bad++; $display("FAIL reset tx_write: got %b want 0", tx_fifo_write_o); end
    total++; if (tx_data_o !== 8'h00) begin bad++; $display("FAIL reset tx_data: got %h want 00", tx_data_o); end
    total++; if (rx_fifo_read_o !== 1'b0) begin bad++; $display("FAIL reset rx_read: got %b want 0", rx_fifo_read_o); end
    total++; if (sanitized_o !== 1'b0) begin bad++; $display("FAIL reset sanitized: got %b want 0", sanitized_o); end
    rst_val = 1'b1;
    repeat (2) cycle();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset idle_after_release: got %b want 0", busy_o); end
  endtask

  task automatic test_happy();
    set_policy(5);
    run_scenario(2'b11, 2'b01, 2'b00, 0);
    total++; if (obs_wd != "43 81 c0 00 ") begin bad++; $display("FAIL happy bytes: got %s want 43 81 c0 00", obs_wd); end
    total++; if (obs_w != exp_w) begin bad++; $display("FAIL happy writes: got %s want %s", obs_w, exp_w); end
    total++; if (obs_p != exp_p) begin bad++; $display("FAIL happy pops: got %s want %s", obs_p, exp_p); end
    total++; if (obs_end != exp_end) begin bad++; $display("FAIL happy end: got %s want %s", obs_end, exp_end); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL happy busy_drop: got %b want 0", busy_after); end
    total++; if (sanitized_o !== 1'b0) begin bad++; $display("FAIL happy sanitized: got %b want 0", sanitized_o); end
  endtask

  task automatic test_retry();
    set_policy(5);
    dly[1] = -1;
    run_scenario(2'b11, 2'b01, 2'b00, 0);
    total++; if (obs_wd != "43 81 81 c0 00 ") begin bad++; $display("FAIL retry bytes: got %s want 43 81 81 c0 00", obs_wd); end
    total++; if (obs_w != exp_w) begin bad++; $display("FAIL retry writes: got %s want %s", obs_w, exp_w); end
    total++; if (obs_end != exp_end) begin bad++; $display("FAIL retry end: got %s want %s", obs_end, exp_end); end
  endtask

  task automatic test_exhaust();
    set_policy(-1);
    run_scenario(2'b11, 2'($urandom), 2'b01, 0);
    total++; if (obs_wd != "43 43 43 ") begin bad++; $display("FAIL exhaust bytes: got %s want 43 43 43", obs_wd); end
    total++; if (obs_w != exp_w) begin bad++; $display("FAIL exhaust writes: got %s want %s", obs_w, exp_w); end
    total++; if (obs_end != exp_end) begin bad++; $display("FAIL exhaust end: got %s want %s", obs_end, exp_end); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL exhaust busy_drop: got %b want 0", busy_after); end
  endtask

  task automatic test_bad_byte();
    set_policy(5);
    rep[0] = 8'h55;
    run_scenario(2'($urandom), 2'($urandom), 2'b10, 0);
    total++; if (obs_p != exp_p) begin bad++; $display("FAIL badbyte pops: got %s want %s", obs_p, exp_p); end
    total++; if (obs_end != exp_end) begin bad++; $display("FAIL badbyte end: got %s want %s", obs_end, exp_end); end
    total++; if (rxq.size() != 0) begin bad++; $display("FAIL badbyte consumed: got %0d left want 0", rxq.size()); end
  endtask

  task automatic test_backpressure();
    set_policy(5);
    dly[0] = -1;
    run_scenario(2'b01, 2'b10, 2'b01, 20);
    total++; if (obs_w != exp_w) begin bad++; $display("FAIL backpressure writes: got %s want %s", obs_w, exp_w); end
    total++; if (obs_end != exp_end) begin bad++; $display("FAIL backpressure end: got %s want %s", obs_end, exp_end); end
  endtask

  task automatic test_tiebreak();
    set_policy(7);
    dly[0] = TO;
    run_scenario(2'b10, 2'b11, 2'b00, 0);
    total++; if (obs_wd != "42 83 c0 00 ") begin bad++; $display("FAIL tiebreak bytes: got %s want 42 83 c0 00", obs_wd); end
    total++; if (obs_w != exp_w) begin bad++; $display("FAIL tiebreak writes: got %s want %s", obs_w, exp_w); end
    total++; if (obs_end != exp_end) begin bad++; $display("FAIL tiebreak end: got %s want %s", obs_end, exp_end); end
  endtask

  task automatic test_sanitize();
    set_policy(3);
    run_scenario(2'b00, 2'b00, 2'b11, 0);
    total++; if (obs_w != exp_w) begin bad++; $display("FAIL sanitize writes: got %s want %s", obs_w, exp_w); end
    total++; if (obs_end != exp_end) begin bad++; $display("FAIL sanitize end: got %s want %s", obs_end, exp_end); end
    total++; if (sanitized_o !== exp_san) begin bad++; $display("FAIL sanitize flag: got %b want %b", sanitized_o, exp_san); end
  endtask

  task automatic test_reset_mid();
    set_policy(-1);
    p_w = 2'b01; p_p = 2'b01; p_s = 2'b01;
    obs_w = ""; obs_wd = ""; obs_p = ""; obs_end = "";
    nwr = 0;
    full_until = 0;
    rxq.delete();
    rxr.delete();
    start_req = 1'b1;
    repeat (6) cycle();
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL resetmid in_wait busy: got %b want 1", busy_o); end
    rxq.push_back(8'hFF);
    rxr.push_back(cyc + 1);
    rst_val = 1'b0;
    cycle();
    total++; if (rx_fifo_read_o !== 1'b0 || tx_fifo_write_o !== 1'b0) begin
      bad++; $display("FAIL resetmid strobes: got rd=%b wr=%b want 0 0", rx_fifo_read_o, tx_fifo_write_o);
    end
    cycle();
    total++; if ({busy_o, done_o, error_o, tx_fifo_write_o, rx_fifo_read_o, sanitized_o, tx_data_o} !== 14'h0) begin
      bad++; $display("FAIL resetmid outputs: got busy=%b done=%b err=%b wr=%b rd=%b san=%b data=%h want all 0",
                      busy_o, done_o, error_o, tx_fifo_write_o, rx_fifo_read_o, sanitized_o, tx_data_o);
    end
    total++; if (obs_end != "") begin bad++; $display("FAIL resetmid pulses: got %s want none", obs_end); end
    rst_val = 1'b1;
    rxq.delete();
    rxr.delete();
    repeat (2) cycle();
  endtask

  task automatic test_random();
    int r;
    logic [1:0] w, p, s;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 9);
        dly[i] = (r < 2) ? -1 : ((r == 2) ? TO : $urandom_range(1, TO));
        rep[i] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 254)) : 8'hFF;
      end
      w = 2'($urandom); p = 2'($urandom); s = 2'($urandom);
      run_scenario(w, p, s, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0);
      total++; if (obs_w != exp_w) begin bad++; $display("FAIL random%0d writes: got %s want %s", n, obs_w, exp_w); end
      total++; if (obs_p != exp_p) begin bad++; $display("FAIL random%0d pops: got %s want %s", n, obs_p, exp_p); end
      total++; if (obs_end != exp_end) begin bad++; $display("FAIL random%0d end: got %s want %s", n, obs_end, exp_end); end
      total++; if (sanitized_o !== exp_san) begin bad++; $display("FAIL random%0d sanitized: got %b want %b", n, sanitized_o, exp_san); end
      total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL random%0d busy_drop: got %b want 0", n, busy_after); end
    end
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0;
    cfg_data_width_i = 2'b00; cfg_parity_mode_i = 2'b00; cfg_stop_bits_i = 2'b00;
    tx_fifo_full_i = 1'b0; rx_fifo_empty_i = 1'b1; rx_data_i = 8'h00;
    p_w = 2'b00; p_p = 2'b00; p_s = 2'b00;
    set_policy(5);
    test_reset();
    test_happy();
    test_retry();
    test_exhaust();
    test_bad_byte();
    test_backpressure();
    test_tiebreak();
    test_reset_mid();
    test_sanitize();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
